// File: rtl/traffic_phase_ctrl.sv
// N-direction intersection phase controller: GREEN -> YELLOW -> ALLRED with round-robin service.
// Optional macro MAX_GREEN_EN caps a contested green at MAX_GREEN cycles.
module traffic_phase_ctrl #(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 16
) (
    input  logic                                              clk,
    input  logic                                              clear,
    input  logic [NUM_DIR-1:0]                                car_req,
    output logic [2*NUM_DIR-1:0]                              lights,
    output logic [((NUM_DIR > 1) ? $clog2(NUM_DIR) : 1)-1:0]  green_dir,
    output logic                                              switching
);
    localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    localparam logic [CNT_W-1:0] MIN_G_END = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_G_END = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_END     = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AR_END    = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] TMR_SAT   = {CNT_W{1'b1}};

    localparam logic [2*NUM_DIR-1:0] LIGHTS_RST = {{(2*NUM_DIR-2){1'b0}}, LAMP_GREEN};

`ifdef MAX_GREEN_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DIR_W-1:0]       r_cur;
    logic [DIR_W-1:0]       w_cur_nxt;
    logic [DIR_W-1:0]       r_tgt;
    logic [DIR_W-1:0]       w_tgt_nxt;
    logic [CNT_W-1:0]       r_timer;
    logic [CNT_W-1:0]       w_timer_nxt;
    logic [CNT_W-1:0]       w_timer_inc;
    logic [2*NUM_DIR-1:0]   r_lights;
    logic [2*NUM_DIR-1:0]   w_lights_nxt;
    logic [DIR_W-1:0]       r_green_dir;
    logic                   r_switching;

    logic [NUM_DIR-1:0]     w_others;
    logic                   w_own;
    logic                   w_max_hit;
    logic                   w_leave;
    logic [DIR_W-1:0]       w_scan;

    // First requesting direction after cur, wrapping; home (0) when nobody else waits.
    function automatic logic [DIR_W-1:0] rr_pick(input logic [DIR_W-1:0] cur,
                                                 input logic [NUM_DIR-1:0] req);
        logic [DIR_W-1:0] pick;
        int               idx;
        pick = '0;
        for (int k = NUM_DIR - 1; k >= 1; k--) begin
            idx = int'(cur) + k;
            if (idx >= NUM_DIR) idx = idx - NUM_DIR;
            if (req[idx[DIR_W-1:0]]) pick = idx[DIR_W-1:0];
        end
        return pick;
    endfunction

    assign w_others    = car_req & ~(NUM_DIR'(1) << r_cur);
    assign w_own       = car_req[r_cur];
    assign w_max_hit   = MAX_EN && (r_timer >= MAX_G_END);
    assign w_leave     = (r_timer >= MIN_G_END) &&
                         (((r_cur != '0) && !w_own) ||
                          ((w_others != '0) && (!w_own || w_max_hit)));
    assign w_scan      = rr_pick(r_cur, w_others);
    assign w_timer_inc = (r_timer == TMR_SAT) ? r_timer : r_timer + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_tgt_nxt   = r_tgt;
        w_timer_nxt = w_timer_inc;
        case (r_state)
            ST_GREEN: begin
                if (w_leave) begin
                    w_state_nxt = ST_YELLOW;
                    w_tgt_nxt   = w_scan;
                    w_timer_nxt = '0;
                end
            end
            ST_YELLOW: begin
                if (r_timer == Y_END) begin
                    w_state_nxt = ST_ALLRED;
                    w_timer_nxt = '0;
                end
            end
            ST_ALLRED: begin
                if (r_timer == AR_END) begin
                    w_state_nxt = ST_GREEN;
                    w_cur_nxt   = r_tgt;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_GREEN;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Lamp image of the next state, so the registered outputs track state exactly.
    always_comb begin
        w_lights_nxt = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            if (DIR_W'(d) == w_cur_nxt) begin
                if (w_state_nxt == ST_GREEN)       w_lights_nxt[2*d +: 2] = LAMP_GREEN;
                else if (w_state_nxt == ST_YELLOW) w_lights_nxt[2*d +: 2] = LAMP_YELLOW;
                else                               w_lights_nxt[2*d +: 2] = LAMP_RED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= ST_GREEN;
            r_cur       <= '0;
            r_tgt       <= '0;
            r_timer     <= '0;
            r_lights    <= LIGHTS_RST;
            r_green_dir <= '0;
            r_switching <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_tgt       <= w_tgt_nxt;
            r_timer     <= w_timer_nxt;
            r_lights    <= w_lights_nxt;
            r_green_dir <= w_cur_nxt;
            r_switching <= (w_state_nxt != ST_GREEN);
        end
    end

    assign lights    = r_lights;
    assign green_dir = r_green_dir;
    assign switching = r_switching;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a 2-direction and a 4-direction instance share clk/clear.
module tb_traffic_phase_ctrl;
    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;

    logic       clk = 1'b0;
    logic       clear;
    logic [1:0] car_req2;
    logic [3:0] car_req4;
    logic [3:0] lights2;
    logic [7:0] lights4;
    logic       dir2;
    logic [1:0] dir4;
    logic       sw2;
    logic       sw4;

    traffic_phase_ctrl u_dut2 (
        .clk(clk), .clear(clear), .car_req(car_req2),
        .lights(lights2), .green_dir(dir2), .switching(sw2)
    );

    traffic_phase_ctrl #(.NUM_DIR(4)) u_dut4 (
        .clk(clk), .clear(clear), .car_req(car_req4),
        .lights(lights4), .green_dir(dir4), .switching(sw4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         inst;
        logic [7:0] lights;
        logic [2:0] dir;
        logic       sw;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   armed  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lp(input int dir, input logic [1:0] code);
        logic [7:0] v;
        v = '0;
        v[2*dir +: 2] = code;
        return v;
    endfunction

    function automatic bit lamps_ok(input logic [7:0] l, input int n);
        int nonred;
        nonred = 0;
        for (int d = 0; d < n; d++) begin
            if (l[2*d +: 2] === 2'd3 || $isunknown(l[2*d +: 2])) return 1'b0;
            if (l[2*d +: 2] != 2'd0) nonred++;
        end
        return (nonred <= 1);
    endfunction

    // Monitor: pop every expectation due at this cycle and compare against the live outputs.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] al;
        logic [2:0] ad;
        logic       as;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.due < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d was never checked (now %0d)", e.name, e.due, cyc);
            end else begin
                if (e.inst == 2) begin
                    al = {4'b0, lights2}; ad = {2'b0, dir2}; as = sw2;
                end else begin
                    al = lights4; ad = {1'b0, dir4}; as = sw4;
                end
                if (al !== e.lights || ad !== e.dir || as !== e.sw) begin
                    n_bad++;
                    $display("FAIL %s (inst%0d cyc %0d): got lights=%b dir=%0d sw=%b, want lights=%b dir=%0d sw=%b",
                             e.name, e.inst, cyc, al, ad, as, e.lights, e.dir, e.sw);
                end
            end
        end
        if (armed) begin
            n_cmp++;
            if (!lamps_ok({4'b0, lights2}, 2)) begin
                n_bad++;
                $display("FAIL lamp_safety2 (cyc %0d): got lights=%b, want one non-red field at most, no 2'd3", cyc, lights2);
            end
            n_cmp++;
            if (!lamps_ok(lights4, 4)) begin
                n_bad++;
                $display("FAIL lamp_safety4 (cyc %0d): got lights=%b, want one non-red field at most, no 2'd3", cyc, lights4);
            end
        end
    end

    task automatic push(input int inst, input logic [7:0] l, input logic [2:0] d,
                        input logic s, input string nm);
        exp_t e;
        e.due = cyc + 1; e.inst = inst; e.lights = l; e.dir = d; e.sw = s; e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int inst, input int n, input logic [1:0] code, input int dir,
                       input logic s, input string nm);
        for (int i = 0; i < n; i++) begin
            push(inst, lp(dir, code), 3'(dir), s, nm);
            tick();
        end
    endtask

    task automatic do_reset(input logic [1:0] c2, input logic [3:0] c4, input string nm);
        clear    = 1'b1;
        car_req2 = c2;
        car_req4 = c4;
        push(2, lp(0, G), 3'd0, 1'b0, nm);
        push(4, lp(0, G), 3'd0, 1'b0, nm);
        tick();
        clear = 1'b0;
        armed = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear    = 1'b0;
        car_req2 = '0;
        car_req4 = '0;
        @(negedge clk);

        // Home road yields to direction 1 after the minimum green.
        do_reset(2'b10, 4'b0000, "s1_reset");
        run(2, 3, G, 0, 1'b0, "s1_green0");
        run(2, 3, Y, 0, 1'b1, "s1_yellow0");
        run(2, 2, R, 0, 1'b1, "s1_allred");
        run(2, 1, G, 1, 1'b0, "s1_green1");

        // Direction 1 holds on its own request, then returns home once it drops.
        run(2, 5, G, 1, 1'b0, "s2_hold1");
        car_req2 = 2'b00;
        run(2, 3, Y, 1, 1'b1, "s2_yellow1");
        run(2, 2, R, 1, 1'b1, "s2_allred");
        run(2, 1, G, 0, 1'b0, "s2_home");
        run(2, 6, G, 0, 1'b0, "s2_rest");

        // Contested home green: capped only when the max-green feature is built in.
        do_reset(2'b11, 4'b0000, "s3_reset");
`ifdef MAX_GREEN_EN
        run(2, 15, G, 0, 1'b0, "s3_maxg_hold");
        run(2, 3, Y, 0, 1'b1, "s3_maxg_yellow");
        run(2, 2, R, 0, 1'b1, "s3_maxg_allred");
        run(2, 1, G, 1, 1'b0, "s3_maxg_next");
`else
        run(2, 205, G, 0, 1'b0, "s3_nomax_hold");
`endif

        // Timer saturates: after 256 idle cycles a request still leaves at once.
        do_reset(2'b00, 4'b0000, "s4_reset");
        run(2, 256, G, 0, 1'b0, "s4_sat_hold");
        car_req2 = 2'b10;
        run(2, 1, Y, 0, 1'b1, "s4_sat_leave");

        // clear during the second yellow cycle restarts a full minimum green.
        do_reset(2'b10, 4'b0000, "s5_reset");
        run(2, 3, G, 0, 1'b0, "s5_green0");
        run(2, 2, Y, 0, 1'b1, "s5_yellow0");
        do_reset(2'b10, 4'b0000, "s5_clear_mid_yellow");
        run(2, 3, G, 0, 1'b0, "s5_green_after_clear");
        run(2, 1, Y, 0, 1'b1, "s5_timer0_leave");

        // Four directions: round-robin target from dir 1 is dir 2, frozen through clearance.
        do_reset(2'b00, 4'b0010, "s6_reset");
        run(4, 3, G, 0, 1'b0, "s6_green0");
        run(4, 3, Y, 0, 1'b1, "s6_yellow0");
        run(4, 2, R, 0, 1'b1, "s6_allred0");
        run(4, 1, G, 1, 1'b0, "s6_green1");
        car_req4 = 4'b1101;
        run(4, 3, G, 1, 1'b0, "s6_green1_min");
        run(4, 1, Y, 1, 1'b1, "s6_yellow1");
        car_req4 = 4'b0001;
        run(4, 1, Y, 1, 1'b1, "s6_yellow1_tog");
        car_req4 = 4'b1000;
        run(4, 1, Y, 1, 1'b1, "s6_yellow1_tog");
        car_req4 = 4'b0011;
        run(4, 1, R, 1, 1'b1, "s6_allred_tog");
        car_req4 = 4'b0001;
        run(4, 1, R, 1, 1'b1, "s6_allred_tog");
        run(4, 1, G, 2, 1'b0, "s6_green2");
        car_req4 = 4'b0100;
        run(4, 2, G, 2, 1'b0, "s6_hold2");

        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-direction intersection phase controller, the successor to the two-road highway/country light controller. It drives a configurable number of approach directions with programmable yellow, all-red, minimum-green and maximum-green durations. Direction 0 is the home (main) road and rests green when there is no competing demand. Competing requests are served round-robin. It sits between the vehicle-sensor synchronisers and the lamp-driver decode.

## Interface
Parameters:
- NUM_DIR, 2: number of approach directions (2..8).
- CNT_W, 8: phase timer width.
- YELLOW_CYC, 3: yellow duration in cycles (≥1).
- ALLRED_CYC, 2: all-red clearance duration in cycles (≥1).
- MIN_GREEN, 4: minimum green duration in cycles (≥1).
- MAX_GREEN, 16: maximum green under competing demand (≥MIN_GREEN, used only with MAX_GREEN_EN).
- All durations must be < 2**CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- clear  in  1  reset, synchronous and active-high.
- car_req  in  NUM_DIR  per-direction demand; bit d=1 means vehicle waiting or present on direction d; pre-synchronised to clk.
- lights  out  2*NUM_DIR  lamp code per direction; field d is lights[2d+1:2d]; RED=2'd0, YELLOW=2'd1, GREEN=2'd2; 2'd3 is never driven.
- green_dir  out  clog2(NUM_DIR) (min 1)  direction currently owning the phase (green or yellow).
- switching  out  1  high during the YELLOW and ALLRED states.

## Operation
- Three-state FSM: GREEN, YELLOW, ALLRED. Registers: cur (owning direction), tgt (next direction), and a timer counting cycles in the current state (0 on entry).
- Every output is registered and reflects the current state only.
  - GREEN: field cur=GREEN, all other fields RED.
  - YELLOW: field cur=YELLOW, all other fields RED.
  - ALLRED: all fields RED.
- others = car_req with bit cur masked off.
- Leave condition in GREEN, evaluated when timer ≥ MIN_GREEN-1:
  - leave = (cur≠0 and !car_req[cur]) or (others≠0 and (!car_req[cur] or max_hit)).
  - max_hit = timer ≥ MAX_GREEN-1.
- On leave: tgt is latched. It is the first set bit of others scanning cur+1, cur+2, … modulo NUM_DIR. If others=0, tgt=0 (return home). The FSM moves to YELLOW.
- YELLOW lasts exactly YELLOW_CYC cycles, then ALLRED.
- ALLRED lasts exactly ALLRED_CYC cycles, then GREEN with cur←tgt and timer←0.
- tgt is frozen from GREEN exit to GREEN entry. car_req changes during YELLOW/ALLRED have no effect on tgt.
- Direction 0 with no others stays GREEN indefinitely. The timer saturates at 2**CNT_W-1 and never wraps.
- Direction d≠0 green with car_req[d]=1 and others=0 holds green indefinitely, even with MAX_GREEN_EN.
- Simultaneous requests are served round-robin, so no direction waits more than NUM_DIR-1 phases.

## Timing
- Reset: clear=1 sampled at a rising edge forces, on that edge:
  - state=GREEN, cur=0, tgt=0, timer=0;
  - lights = direction 0 GREEN, all others RED;
  - green_dir=0, switching=0.
- clear overrides everything, including mid-YELLOW/ALLRED. There is no partial clearance after reset.
- Decision latency: leave is evaluated from the registered state and the current car_req. Lamps change on the next edge, i.e. one cycle after the qualifying car_req sample.
- Green length: at least MIN_GREEN cycles. Exactly MIN_GREEN if leave already holds at timer=MIN_GREEN-1.
- Minimum full handover: MIN_GREEN + YELLOW_CYC + ALLRED_CYC cycles from green entry to the next green.
- A direction never goes GREEN without ≥ALLRED_CYC preceding all-red cycles. Two fields are never simultaneously non-RED.

## Configuration
- MAX_GREEN_EN defined: max_hit is active. A direction holding green with its own request still asserted is forced to yield after MAX_GREEN cycles when others≠0.
- MAX_GREEN_EN undefined: max_hit is tied 0 and the MAX_GREEN parameter is ignored. A green persists while its own request stays asserted, regardless of competing demand (the legacy two-road behaviour).

## Test plan
Defaults apply (NUM_DIR=2, YELLOW_CYC=3, ALLRED_CYC=2, MIN_GREEN=4, MAX_GREEN=16).
- Reset then car_req=2'b10 held -> lights sequence:
  - field0 GREEN 4 cycles, YELLOW 3, all RED 2;
  - field1 GREEN on cycle 10 after reset release, with green_dir=1 and switching low.
- Direction 1 green, then car_req→2'b00 -> after ≥MIN_GREEN green cycles: field1 YELLOW 3, all-red 2, direction 0 GREEN; direction 0 then holds while car_req=0.
- Direction 0 green, car_req=2'b11 held, MAX_GREEN_EN defined -> direction 0 yields after exactly 16 green cycles. Without the macro -> direction 0 stays GREEN for >200 cycles.
- NUM_DIR=4, cur=1, car_req=4'b1101 with own request dropped -> tgt=2 latched; toggling car_req during YELLOW does not change the next green (direction 2).
- clear asserted on the 2nd YELLOW cycle -> next edge: direction 0 GREEN, others RED, timer 0, switching 0.
- All runs: assertion that at most one field is non-RED and lights never equals 2'd3 in any field.
